// File: rtl/read_control_pkg.sv
// Shared constants and output-buffer state encoding for the synchronous FIFO read side.
package read_control_pkg;
    localparam int FIFO_DEPTH      = 8;
    localparam int FIFO_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        RB_EMPTY = 2'd0,
        RB_ONE   = 2'd1,
        RB_TWO   = 2'd2
    } rb_state_t;
endpackage

// File: rtl/read_out_buffer.sv
// Two-entry head+skid output register pair; out_data is the head, skid holds the next word.
module read_out_buffer
    import read_control_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            count
);
    rb_state_t             state;
    logic [DATA_WIDTH-1:0] skid;
    logic                  pop;

    assign pop   = out_valid && out_ready;
    assign count = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RB_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid      <= '0;
        end else begin
            case (state)
                RB_EMPTY: begin
                    if (in_valid) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= RB_ONE;
                    end
                end
                RB_ONE: begin
                    if (in_valid && pop) begin
                        out_data <= in_data;
                    end else if (in_valid) begin
                        skid  <= in_data;
                        state <= RB_TWO;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= RB_EMPTY;
                    end
                end
                RB_TWO: begin
                    if (pop) begin
                        out_data <= skid;
                        if (in_valid) begin
                            skid <= in_data;
                        end else begin
                            state <= RB_ONE;
                        end
                    end
                end
                default: begin
                    state     <= RB_EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // The issue logic never lets a third word arrive while both slots are held.
    assert property (@(posedge clk) disable iff (reset)
        !(state == RB_TWO && in_valid && !out_ready));
endmodule

// File: rtl/read_control.sv
// Read-side FIFO controller: empty detection, read issue to a 1-cycle memory, FWFT output.
module read_control
    import read_control_pkg::*;
#(
    parameter int MEM_DEPTH  = FIFO_DEPTH,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  rd_ready,
    output logic                  rd_en,
    output logic [ADDR_WIDTH:0]   rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_empty,
    output logic                  fifo_empty
);
    localparam int PW = ADDR_WIDTH + 1;

    logic       inflight;
    logic [1:0] buf_cnt;
    logic       pop;
    logic [2:0] occ_after;

    assign pop        = rd_valid && rd_ready;
    assign mem_empty  = (wr_addr == rd_addr);
    assign fifo_empty = mem_empty && !inflight && (buf_cnt == 2'd0);

    // Occupancy left after this cycle's pop; a read is only issued if its word has a slot.
    assign occ_after = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
    assign rd_en     = !mem_empty && (occ_after < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                rd_addr <= rd_addr + PW'(1);
            end
        end
    end

    read_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight),
        .in_data   (mem_rdata),
        .out_valid (rd_valid),
        .out_data  (rd_data),
        .out_ready (rd_ready),
        .count     (buf_cnt)
    );
endmodule
